dma_channel_sequencer: RTL and testbench
========================================

Name: dma_channel_sequencer

Overview:
- Multi-channel DMA sequencer that is programmed over the 8-bit CPU data bus.
- Holds a 16-bit current address and a 16-bit remaining word count per channel. Each value is loaded as two byte writes, high byte first, through a shared byte-pointer flip-flop.
- Arbitrates device requests with rotating priority and runs a bus-hold handshake.
- Issues one single-cycle transfer per grant, then increments the address, decrements the count and flags terminal count.

Parameters:
- NCH, 4, number of channels (1..4); wr_ch stays 2 bits wide.
- AW, 16, address and count width (fixed at two bytes).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- RESET_n  in  1  asynchronous active-low reset.
- data_bus  in  8  CPU write data byte.
- wr_en  in  1  one-cycle byte-write strobe.
- wr_ch  in  2  target channel of the write.
- wr_reg  in  1  0 = address register, 1 = count register.
- clear_ff  in  1  forces the byte pointer to "high byte next".
- dreq  in  NCH  per-channel device request, level sensitive.
- hold_ack  in  1  bus granted by the system.
- hold_req  out  1  bus request.
- dack  out  NCH  one-hot transfer acknowledge.
- mem_addr  out  16  transfer address.
- xfer_strobe  out  1  transfer-active pulse.
- tc  out  1  terminal-count pulse.
- tc_ch  out  2  channel that reached terminal count.
- wr_err  out  1  a write was rejected.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset (async on RESET_n low, released synchronously):
  - all per-channel address, count and armed bits = 0; byte pointer = 0.
  - last_grant = NCH-1, so channel 0 has highest priority first.
  - FSM = IDLE; every output = 0.
- Byte pointer:
  - Each wr_en toggles the pointer.
  - ptr = 0: data_bus goes into the staging byte (high byte).
  - ptr = 1: the value {staging, data_bus} is committed to the register selected by wr_ch/wr_reg.
  - clear_ff forces ptr = 0. If clear_ff and wr_en occur in the same cycle, clear_ff applies first and the byte is taken as the high byte.
- Commit rules:
  - Count commit sets armed[ch] = (value != 0).
  - Address commit leaves armed unchanged.
  - A commit to the channel currently in XFER or UPDATE is dropped and wr_err pulses for 1 cycle. The pointer still toggles.
- Eligibility: eligible[i] = dreq[i] & armed[i].
- FSM states (Moore; hold_req is high in HOLD_WAIT, XFER and UPDATE):
  - IDLE: if any channel is eligible, go to HOLD_WAIT, so hold_req rises 1 cycle after eligibility.
  - HOLD_WAIT: wait indefinitely for hold_ack. On hold_ack, re-arbitrate:
    - winner = first eligible channel searching from last_grant+1 upward, wrapping modulo NCH.
    - If no channel is eligible any more (dreq withdrawn), return to IDLE with no transfer.
    - Otherwise latch the winner, set last_grant = winner, go to XFER.
  - XFER (exactly 1 cycle):
    - dack[winner] = 1, xfer_strobe = 1, mem_addr = addr[winner].
    - hold_ack and dreq are ignored; the transfer always completes.
  - UPDATE (1 cycle):
    - dack = 0, xfer_strobe = 0; mem_addr holds its value.
    - addr[winner] += 1, wrapping 0xFFFF to 0x0000.
    - count[winner] -= 1. If the result is 0: tc = 1 and tc_ch = winner for this cycle, and armed[winner] is cleared.
    - Then go to IDLE.
- Single-transfer mode only:
  - hold_req drops in IDLE, giving a minimum 4-cycle period per transfer: IDLE, HOLD_WAIT, XFER, UPDATE.
  - A continuously asserted dreq is re-requested from IDLE.
- Transfer count: count N gives exactly N transfers; count 0 means disarmed.
- Reset mid-operation aborts immediately; no partial increment is kept.
- mem_addr, dack, xfer_strobe, tc and tc_ch are registered or state-decoded. No combinational path runs from any input to any output.

Test Plan:
1. Single channel, two words:
   - Stimulus: writes ch0 address 0x12,0x34 and count 0x00,0x02; dreq0 = 1; hold_ack = hold_req delayed 1 cycle.
   - Required: two XFER cycles with mem_addr 0x1234 then 0x1235; tc = 1 with tc_ch = 0 in the second UPDATE; armed[0] = 0 and no further hold_req.
2. Rotating priority:
   - Stimulus: ch0 and ch2 programmed with count 3, both dreq high.
   - Required: dack order 0, 2, 0, 2, 0, 2; both tc pulses occur.
3. Address wrap:
   - Stimulus: address 0xFFFF, count 2.
   - Required: mem_addr 0xFFFF then 0x0000; final address register 0x0001.
4. Byte pointer:
   - Stimulus: write 0xAB, pulse clear_ff, then write 0x56,0x78 to the ch1 address.
   - Required: ch1 address = 0x5678.
   - Stimulus: a single 0xAB write followed by a count write without clear_ff.
   - Required: the count is committed as {0xAB, first count byte}.
5. Illegal write and withdrawn request:
   - Stimulus: commit to ch0 during its XFER.
   - Required: wr_err = 1, registers unchanged.
   - Stimulus: dreq dropped during HOLD_WAIT, then hold_ack.
   - Required: return to IDLE, no dack.
6. Reset mid-operation:
   - Stimulus: RESET_n low during XFER.
   - Required: same cycle, dack = 0 and hold_req = 0 with all registers 0; after release, no activity until channels are reprogrammed.

Source files
------------

// File: rtl/dma_channel_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : dma_channel_sequencer_if                                  |
// | Brief  : CPU programming bus, device requests and bus-hold port.   |
// | Rev    : 1.0                                                       |
// +--------------------------------------------------------------------+
interface dma_channel_sequencer_if #(
  parameter int NCH = 4,
  parameter int AW  = 16
);
  logic [7:0]     data_bus;
  logic           wr_en;
  logic [1:0]     wr_ch;
  logic           wr_reg;
  logic           clear_ff;
  logic [NCH-1:0] dreq;
  logic           hold_ack;
  logic           hold_req;
  logic [NCH-1:0] dack;
  logic [AW-1:0]  mem_addr;
  logic           xfer_strobe;
  logic           tc;
  logic [1:0]     tc_ch;
  logic           wr_err;
  logic           busy;

  modport master (
    output data_bus, wr_en, wr_ch, wr_reg, clear_ff, dreq, hold_ack,
    input  hold_req, dack, mem_addr, xfer_strobe, tc, tc_ch, wr_err, busy
  );

  modport slave (
    input  data_bus, wr_en, wr_ch, wr_reg, clear_ff, dreq, hold_ack,
    output hold_req, dack, mem_addr, xfer_strobe, tc, tc_ch, wr_err, busy
  );
endinterface
`default_nettype wire

// File: rtl/dma_channel_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : dma_channel_sequencer                                     |
// | Brief  : Byte-programmed multi-channel DMA sequencer, rotating     |
// |          priority, one single-cycle transfer per bus-hold grant.   |
// | Rev    : 1.0                                                       |
// +--------------------------------------------------------------------+
module dma_channel_sequencer #(
  parameter int NCH = 4,
  parameter int AW  = 16
) (
  input  logic                    clk,
  input  logic                    RESET_n,
  dma_channel_sequencer_if.slave  bus
);

  localparam logic [1:0]    c_IDLE      = 2'd0;
  localparam logic [1:0]    c_HOLD_WAIT = 2'd1;
  localparam logic [1:0]    c_XFER      = 2'd2;
  localparam logic [1:0]    c_UPDATE    = 2'd3;
  localparam logic [AW-1:0] c_ONE       = 1;

  logic [1:0]     state_q, state_d;
  logic           ptr_q;
  logic [7:0]     stage_q;
  logic [AW-1:0]  addr_q [NCH];
  logic [AW-1:0]  cnt_q  [NCH];
  logic [NCH-1:0] armed_q;
  logic [1:0]     last_grant_q;
  logic [1:0]     win_q;
  logic [AW-1:0]  mem_addr_q;
  logic           wr_err_q;

  logic [NCH-1:0] w_elig;
  logic [3:0]     w_elig_ext;
  logic [1:0]     w_cand;
  logic [1:0]     w_arb_idx;
  logic           w_arb_found;
  logic           w_ptr_eff;
  logic           w_commit;
  logic           w_blocked;
  logic           w_grant;
  logic           w_update;
  logic [AW-1:0]  w_val;
  logic [3:0]     w_onehot;

  assign w_elig    = bus.dreq & armed_q;
  assign w_ptr_eff = ptr_q & ~bus.clear_ff;
  assign w_commit  = bus.wr_en & w_ptr_eff;
  assign w_blocked = ((state_q == c_XFER) || (state_q == c_UPDATE)) && (bus.wr_ch == win_q);
  assign w_val     = {stage_q, bus.data_bus};
  assign w_grant   = (state_q == c_HOLD_WAIT) && bus.hold_ack && w_arb_found;
  assign w_update  = (state_q == c_UPDATE);
  assign w_onehot  = 4'b0001 << win_q;

  // Scanning from farthest to nearest lets the nearest eligible channel after last_grant win.
  always_comb begin
    w_elig_ext          = '0;
    w_elig_ext[NCH-1:0] = w_elig;
    w_arb_found         = 1'b0;
    w_arb_idx           = last_grant_q;
    w_cand              = '0;
    for (int k = NCH; k >= 1; k--) begin
      w_cand = 2'((int'(last_grant_q) + k) % NCH);
      if (w_elig_ext[w_cand]) begin
        w_arb_found = 1'b1;
        w_arb_idx   = w_cand;
      end
    end
  end

  always_ff @(posedge clk or negedge RESET_n) begin
    if (!RESET_n) state_q <= c_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      c_IDLE:      if (|w_elig) state_d = c_HOLD_WAIT;
      c_HOLD_WAIT: if (bus.hold_ack) state_d = w_arb_found ? c_XFER : c_IDLE;
      c_XFER:      state_d = c_UPDATE;
      default:     state_d = c_IDLE;
    endcase
  end

  always_comb begin
    bus.hold_req    = 1'b0;
    bus.dack        = '0;
    bus.xfer_strobe = 1'b0;
    bus.tc          = 1'b0;
    bus.tc_ch       = '0;
    bus.busy        = (state_q != c_IDLE);
    bus.mem_addr    = mem_addr_q;
    bus.wr_err      = wr_err_q;
    case (state_q)
      c_HOLD_WAIT: bus.hold_req = 1'b1;
      c_XFER: begin
        bus.hold_req    = 1'b1;
        bus.xfer_strobe = 1'b1;
        bus.dack        = w_onehot[NCH-1:0];
      end
      c_UPDATE: begin
        bus.hold_req = 1'b1;
        if (cnt_q[win_q] == c_ONE) begin
          bus.tc    = 1'b1;
          bus.tc_ch = win_q;
        end
      end
      default: ;
    endcase
  end

  // A dropped commit still consumes its byte slot, so the pointer toggles on every wr_en.
  always_ff @(posedge clk or negedge RESET_n) begin
    if (!RESET_n) begin
      ptr_q        <= 1'b0;
      stage_q      <= '0;
      armed_q      <= '0;
      last_grant_q <= 2'(NCH - 1);
      win_q        <= '0;
      mem_addr_q   <= '0;
      wr_err_q     <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        addr_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
    end else begin
      wr_err_q <= w_commit & w_blocked;
      if (bus.wr_en) begin
        ptr_q <= ~w_ptr_eff;
        if (!w_ptr_eff) stage_q <= bus.data_bus;
      end else if (bus.clear_ff) begin
        ptr_q <= 1'b0;
      end
      if (w_grant) begin
        win_q        <= w_arb_idx;
        last_grant_q <= w_arb_idx;
        mem_addr_q   <= addr_q[w_arb_idx];
      end
      for (int i = 0; i < NCH; i++) begin
        if (w_update && (win_q == 2'(i))) begin
          addr_q[i] <= addr_q[i] + c_ONE;
          cnt_q[i]  <= cnt_q[i] - c_ONE;
          if (cnt_q[i] == c_ONE) armed_q[i] <= 1'b0;
        end
        if (w_commit && !w_blocked && (bus.wr_ch == 2'(i))) begin
          if (bus.wr_reg) begin
            cnt_q[i]   <= w_val;
            armed_q[i] <= |w_val;
          end else begin
            addr_q[i] <= w_val;
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dma_channel_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : tb_dma_channel_sequencer                                  |
// | Brief  : Directed and randomized bench with a transfer-level model.|
// | Rev    : 1.0                                                       |
// +--------------------------------------------------------------------+
module tb_dma_channel_sequencer;
  localparam int NCH = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dma_channel_sequencer_if #(.NCH(NCH), .AW(16)) bus ();
  dma_channel_sequencer #(.NCH(NCH), .AW(16)) dut (.clk(clk), .RESET_n(rst_n), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;

  // Transfer-level reference: per-channel address/count/armed, rotating grant pointer.
  int unsigned m_addr [NCH];
  int unsigned m_cnt  [NCH];
  bit          m_armed[NCH];
  int          m_last;
  bit          m_ptr;
  logic [7:0]  m_stage;

  bit ack_auto, prev_hreq, exp_tc, exp_err;
  int exp_tc_ch, busy_left, busy_ch;
  int n_xfer, n_tc, hreq_cycles;
  int          log_ch[$];
  int unsigned log_addr[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_addr[c] = 0; m_cnt[c] = 0; m_armed[c] = 0;
    end
    m_last = NCH - 1; m_ptr = 0; m_stage = 0;
    busy_left = 0; busy_ch = -1; exp_tc = 0; exp_err = 0; prev_hreq = 0;
  endfunction

  function automatic int exp_winner();
    for (int k = 1; k <= NCH; k++) begin
      int c;
      c = (m_last + k) % NCH;
      if (bus.dreq[c] && m_armed[c]) return c;
    end
    return -1;
  endfunction

  task automatic cycle();
    int w, oc;
    @(posedge clk); #1;
    chk("wr_err", bus.wr_err, exp_err);
    exp_err = 0;
    chk("tc", bus.tc, exp_tc);
    if (exp_tc) chk("tc_ch", bus.tc_ch, exp_tc_ch);
    exp_tc = 0;
    if (bus.tc) n_tc++;
    if (busy_left > 0) busy_left--;
    if (bus.hold_req) hreq_cycles++;
    if (bus.xfer_strobe) begin
      w = exp_winner();
      chk("xfer_expected", (w >= 0), 1);
      if (w >= 0) begin
        chk("dack", bus.dack, 32'(1) << w);
        chk("mem_addr", bus.mem_addr, m_addr[w]);
        oc = -1;
        for (int c = 0; c < NCH; c++) if (bus.dack[c]) oc = c;
        log_ch.push_back(oc);
        log_addr.push_back(bus.mem_addr);
        n_xfer++;
        m_last = w;
        m_addr[w] = (m_addr[w] + 1) & 32'hFFFF;
        m_cnt[w] = m_cnt[w] - 1;
        if (m_cnt[w] == 0) begin
          m_armed[w] = 0; exp_tc = 1; exp_tc_ch = w;
        end
        busy_left = 2; busy_ch = w;
      end
    end else begin
      chk("dack_idle", bus.dack, 0);
    end
    if (ack_auto) bus.hold_ack = prev_hreq;
    prev_hreq = bus.hold_req;
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic wr_byte(input int ch, input bit rg, input logic [7:0] d, input bit clr);
    bus.data_bus = d; bus.wr_ch = 2'(ch); bus.wr_reg = rg; bus.wr_en = 1'b1; bus.clear_ff = clr;
    if (clr) m_ptr = 0;
    if (!m_ptr) begin
      m_stage = d; m_ptr = 1;
    end else begin
      m_ptr = 0;
      if (busy_left > 0 && busy_ch == ch) exp_err = 1;
      else if (rg) begin
        m_cnt[ch] = {m_stage, d}; m_armed[ch] = ({m_stage, d} != 16'h0);
      end else m_addr[ch] = {m_stage, d};
    end
    cycle();
    bus.wr_en = 1'b0; bus.clear_ff = 1'b0;
  endtask

  task automatic wr16(input int ch, input bit rg, input logic [15:0] v);
    wr_byte(ch, rg, v[15:8], 1'b1);
    wr_byte(ch, rg, v[7:0], 1'b0);
  endtask

  task automatic wait_xfer(input string tag, input int max_cyc);
    int k;
    k = 0;
    do begin cycle(); k++; end while (!bus.xfer_strobe && k < max_cyc);
    chk(tag, bus.xfer_strobe, 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; bus.dreq = '0; bus.hold_ack = 1'b0; bus.wr_en = 1'b0; bus.clear_ff = 1'b0;
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, t0, k, exp_n;
    logic [3:0] mask;
    bus.data_bus = '0; bus.wr_en = 1'b0; bus.wr_ch = '0; bus.wr_reg = 1'b0;
    bus.clear_ff = 1'b0; bus.dreq = '0; bus.hold_ack = 1'b0;
    ack_auto = 1; n_xfer = 0; n_tc = 0; hreq_cycles = 0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold_req", bus.hold_req, 0);
    chk("rst_dack", bus.dack, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_xfer", bus.xfer_strobe, 0);
    chk("rst_tc", {bus.tc, bus.tc_ch}, 0);
    chk("rst_wr_err", bus.wr_err, 0);
    chk("rst_busy", bus.busy, 0);
    rst_n = 1'b1;

    // Single channel, two words
    wr16(0, 0, 16'h1234);
    wr16(0, 1, 16'h0002);
    log_addr.delete(); t0 = n_tc;
    bus.dreq = 4'b0001;
    run(20);
    chk("t1_nxfer", log_addr.size(), 2);
    if (log_addr.size() >= 2) begin
      chk("t1_addr0", log_addr[0], 32'h1234);
      chk("t1_addr1", log_addr[1], 32'h1235);
    end
    chk("t1_ntc", n_tc - t0, 1);
    hreq_cycles = 0;
    run(8);
    chk("t1_no_rerequest", hreq_cycles, 0);
    bus.dreq = '0;

    // Rotating priority from a fresh grant pointer
    do_reset();
    wr16(0, 1, 16'h0003);
    wr16(2, 0, 16'h2000);
    wr16(2, 1, 16'h0003);
    log_ch.delete(); t0 = n_tc;
    bus.dreq = 4'b0101;
    run(60);
    chk("t2_nxfer", log_ch.size(), 6);
    for (int i = 0; i < 6 && i < log_ch.size(); i++) chk("t2_order", log_ch[i], (i % 2 == 0) ? 0 : 2);
    chk("t2_ntc", n_tc - t0, 2);
    bus.dreq = '0;

    // Address wrap
    wr16(3, 0, 16'hFFFF);
    wr16(3, 1, 16'h0002);
    log_addr.delete();
    bus.dreq = 4'b1000;
    run(20);
    chk("t3_nxfer", log_addr.size(), 2);
    if (log_addr.size() >= 2) begin
      chk("t3_addr0", log_addr[0], 32'hFFFF);
      chk("t3_addr1", log_addr[1], 32'h0000);
    end
    bus.dreq = '0;
    wr16(3, 1, 16'h0001);
    bus.dreq = 4'b1000;
    run(12);
    chk("t3_final_addr", log_addr[$], 32'h0001);
    bus.dreq = '0;

    // Byte pointer: clear_ff realigns
    wr_byte(1, 0, 8'hAB, 1'b1);
    bus.clear_ff = 1'b1; m_ptr = 0; cycle(); bus.clear_ff = 1'b0;
    wr_byte(1, 0, 8'h56, 1'b0);
    wr_byte(1, 0, 8'h78, 1'b0);
    wr16(1, 1, 16'h0001);
    bus.dreq = 4'b0010;
    run(12);
    chk("t4_addr", log_addr[$], 32'h5678);
    bus.dreq = '0;
    // Stray high byte: count becomes {0xAB, 0x00}
    wr_byte(2, 1, 8'hAB, 1'b1);
    wr_byte(2, 1, 8'h00, 1'b0);
    wr_byte(2, 1, 8'h03, 1'b0);
    n0 = n_xfer;
    bus.dreq = 4'b0100;
    run(15);
    chk("t4_stray_armed", (n_xfer > n0), 1);
    bus.dreq = '0;
    run(3);
    bus.clear_ff = 1'b1; m_ptr = 0; cycle(); bus.clear_ff = 1'b0;
    wr_byte(1, 1, 8'h00, 1'b0);
    wr_byte(1, 1, 8'h01, 1'b0);
    wr_byte(1, 1, 8'hEE, 1'b0);
    n0 = n_xfer; t0 = n_tc;
    bus.dreq = 4'b0010;
    run(12);
    chk("t4_stray_cnt1_xfer", n_xfer - n0, 1);
    chk("t4_stray_cnt1_tc", n_tc - t0, 1);
    bus.dreq = '0;

    // Commit rejected during XFER
    do_reset();
    wr16(0, 0, 16'h4000);
    wr16(0, 1, 16'h0003);
    wr_byte(0, 0, 8'h99, 1'b1);
    log_addr.delete();
    bus.dreq = 4'b0001;
    wait_xfer("t5_xfer_timeout", 20);
    wr_byte(0, 0, 8'h99, 1'b0);
    run(30);
    chk("t5_nxfer", log_addr.size(), 3);
    chk("t5_last_addr", log_addr[$], 32'h4002);
    bus.dreq = '0;

    // Withdrawn request during HOLD_WAIT
    ack_auto = 0; bus.hold_ack = 1'b0;
    wr16(1, 1, 16'h0001);
    n0 = n_xfer;
    bus.dreq = 4'b0010;
    k = 0;
    do begin cycle(); k++; end while (!bus.hold_req && k < 10);
    chk("t5_hold_req_timeout", bus.hold_req, 1);
    bus.dreq = '0;
    cycle();
    bus.hold_ack = 1'b1;
    run(3);
    chk("t5_withdraw_idle", {bus.busy, bus.hold_req}, 0);
    chk("t5_withdraw_nodack", n_xfer - n0, 0);
    bus.hold_ack = 1'b0; ack_auto = 1;

    // Reset mid-transfer
    do_reset();
    wr16(0, 0, 16'h1000);
    wr16(0, 1, 16'h0005);
    bus.dreq = 4'b0001;
    wait_xfer("t6_xfer_timeout", 20);
    rst_n = 1'b0;
    model_reset();
    bus.hold_ack = 1'b0;
    #1;
    chk("t6_dack", bus.dack, 0);
    chk("t6_hold_req", bus.hold_req, 0);
    chk("t6_outputs", {bus.xfer_strobe, bus.busy, bus.tc, bus.mem_addr}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    hreq_cycles = 0;
    run(10);
    chk("t6_quiet", hreq_cycles, 0);
    wr16(0, 1, 16'h0001);
    run(12);
    chk("t6_addr_cleared", log_addr[$], 32'h0000);
    bus.dreq = '0;

    // Randomized programming and request masks
    do_reset();
    for (int r = 0; r < 6; r++) begin
      bus.dreq = '0;
      for (int c = 0; c < NCH; c++) begin
        if ($urandom_range(0, 1) == 1) begin
          wr16(c, 0, 16'($urandom_range(0, 65535)));
          wr16(c, 1, 16'($urandom_range(0, 4)));
        end
      end
      mask = 4'($urandom_range(0, 15));
      exp_n = 0;
      for (int c = 0; c < NCH; c++) if (mask[c] && m_armed[c]) exp_n += int'(m_cnt[c]);
      n0 = n_xfer;
      bus.dreq = mask;
      run(130);
      chk("rand_nxfer", n_xfer - n0, exp_n);
      chk("rand_drained", bus.busy, 0);
      bus.dreq = '0;
      run(2);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
